// File: rtl/fir_pkg.sv
// Shared constants, state encoding and width helper for the FIR MAC stage.
package fir_pkg;

    localparam int NTAPS  = 8;
    localparam int ADDR_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN
    } state_e;

    // log2(NTAPS) guard bits keep the 8-tap sum from overflowing.
    function automatic int acc_width(input int dw, input int cw);
        return dw + cw + ADDR_W;
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Signed multiply with an accumulate register; sum_o is the running total
// plus the current product, so the last tap can be folded in without a write-back.
module fir_mac_unit #(
    parameter int DataW = 8,
    parameter int CoefW = 8,
    parameter int AccW  = 19
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic signed [DataW-1:0] a_i,
    input  logic signed [CoefW-1:0] b_i,
    output logic signed [AccW-1:0]  sum_o
);

    localparam int ProdW = DataW + CoefW;

    logic signed [ProdW-1:0] prod;
    logic signed [AccW-1:0]  acc_q;

    assign prod  = ProdW'(a_i) * ProdW'(b_i);
    assign sum_o = acc_q + AccW'(prod);

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= sum_o;
        end
    end

endmodule

// File: rtl/fir_mac_ctrl.sv
// Sequencer between the upstream handshake and the 8-entry delay line:
// write one sample, read taps 0..7 back, and emit the full-precision MAC result.
module fir_mac_ctrl
    import fir_pkg::*;
#(
    parameter int                         data_width = 8,
    parameter int                         coef_width = 8,
    parameter logic [NTAPS*coef_width-1:0] COEFS     =
        {8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd4, 8'sd3, 8'sd2, 8'sd1}
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic                                          in_valid,
    input  logic [data_width-1:0]                         in_data,
    output logic                                          in_ready,
    output logic                                          ram_en,
    output logic                                          ram_we,
    output logic [ADDR_W-1:0]                             ram_addr,
    output logic [data_width-1:0]                         ram_di,
    input  logic [data_width-1:0]                         ram_dio,
    output logic                                          y_valid,
    output logic signed [data_width+coef_width+ADDR_W-1:0] y_data
);

    localparam int AccW = acc_width(data_width, coef_width);

    state_e                 state_q, state_d;
    logic [ADDR_W-1:0]      tapCnt_q, tapCnt_d;
    logic [data_width-1:0]  sample_q, sample_d;
    logic [ADDR_W-1:0]      kDly_q;
    logic                   prodValid_q;
    logic                   yValid_q;
    logic signed [AccW-1:0] yData_q;

    logic                   macClr;
    logic                   macEn;
    logic signed [coef_width-1:0] coefSel;
    logic signed [AccW-1:0] macSum;

    always_comb begin
        state_d  = state_q;
        tapCnt_d = tapCnt_q;
        sample_d = sample_q;
        in_ready = 1'b0;
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_di   = '0;
        macClr   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sample_d = in_data;
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_di   = sample_q;
                macClr   = 1'b1;
                tapCnt_d = '0;
                state_d  = READ;
            end
            READ: begin
                ram_en   = 1'b1;
                ram_addr = tapCnt_q;
                tapCnt_d = tapCnt_q + 1'b1;
                if (tapCnt_q == ADDR_W'(NTAPS - 1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read data lags the address by one cycle, so the tap index is delayed to match it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            tapCnt_q    <= '0;
            sample_q    <= '0;
            kDly_q      <= '0;
            prodValid_q <= 1'b0;
            yValid_q    <= 1'b0;
            yData_q     <= '0;
        end else begin
            state_q     <= state_d;
            tapCnt_q    <= tapCnt_d;
            sample_q    <= sample_d;
            kDly_q      <= tapCnt_q;
            prodValid_q <= (state_q == READ);
            yValid_q    <= (state_q == DRAIN);
            if (state_q == DRAIN) begin
                yData_q <= macSum;
            end
        end
    end

    assign coefSel = COEFS[int'(kDly_q)*coef_width +: coef_width];
    assign macEn   = prodValid_q && (state_q == READ);

    fir_mac_unit #(
        .DataW (data_width),
        .CoefW (coef_width),
        .AccW  (AccW)
    ) u_mac (
        .clock (clock),
        .reset (reset),
        .clr_i (macClr),
        .en_i  (macEn),
        .a_i   ($signed(ram_dio)),
        .b_i   (coefSel),
        .sum_o (macSum)
    );

    assign y_valid = yValid_q;
    assign y_data  = yData_q;

endmodule

// File: tb/tb_fir_mac_ctrl.sv
// Scoreboard bench for fir_mac_ctrl with behavioural delay-line models;
// instance A uses the default taps, instance B uses all-127 taps for the extreme case.
module tb_fir_mac_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic              inValidA = 1'b0, inValidB = 1'b0;
    logic [7:0]        inDataA = '0, inDataB = '0;
    logic              inReadyA, inReadyB;
    logic              ramEnA, ramEnB, ramWeA, ramWeB;
    logic [2:0]        ramAddrA, ramAddrB;
    logic [7:0]        ramDiA, ramDiB;
    logic [7:0]        doutA, doutB;
    logic              yValidA, yValidB;
    logic signed [18:0] yDataA, yDataB;

    logic [7:0] lineA [8];
    logic [7:0] lineB [8];

    int compared   = 0;
    int mismatched = 0;

    int expQA[$];
    int expQB[$];
    int acceptQ[$];

    int cyc        = 0;
    int lastAccept = 0;
    bit busy       = 1'b0;
    bit haveAccept = 1'b0;
    bit validRun   = 1'b0;

    always #5 clock = ~clock;

    fir_mac_ctrl dutA (
        .clock    (clock),
        .reset    (reset),
        .in_valid (inValidA),
        .in_data  (inDataA),
        .in_ready (inReadyA),
        .ram_en   (ramEnA),
        .ram_we   (ramWeA),
        .ram_addr (ramAddrA),
        .ram_di   (ramDiA),
        .ram_dio  (doutA),
        .y_valid  (yValidA),
        .y_data   (yDataA)
    );

    fir_mac_ctrl #(
        .COEFS ({8{8'h7f}})
    ) dutB (
        .clock    (clock),
        .reset    (reset),
        .in_valid (inValidB),
        .in_data  (inDataB),
        .in_ready (inReadyB),
        .ram_en   (ramEnB),
        .ram_we   (ramWeB),
        .ram_addr (ramAddrB),
        .ram_di   (ramDiB),
        .ram_dio  (doutB),
        .y_valid  (yValidB),
        .y_data   (yDataB)
    );

    // Delay line: a write shifts the history and puts di at address 0; reads are registered.
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) lineA[i] <= '0;
            doutA <= '0;
        end else if (ramEnA) begin
            if (ramWeA) begin
                for (int i = 7; i > 0; i--) lineA[i] <= lineA[i-1];
                lineA[0] <= ramDiA;
            end else begin
                doutA <= lineA[ramAddrA];
            end
        end
    end

    always @(posedge clock) begin
        if (reset) begin
            for (int j = 0; j < 8; j++) lineB[j] <= '0;
            doutB <= '0;
        end else if (ramEnB) begin
            if (ramWeB) begin
                for (int j = 7; j > 0; j--) lineB[j] <= lineB[j-1];
                lineB[0] <= ramDiB;
            end else begin
                doutB <= lineB[ramAddrB];
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit useB, input logic [7:0] data, input int expVal,
                                 input bit keepValid, output int waits);
        bit ok;
        ok    = 1'b0;
        waits = 0;
        if (useB) begin
            expQB.push_back(expVal);
            inDataB  = data;
            inValidB = 1'b1;
        end else begin
            expQA.push_back(expVal);
            inDataA  = data;
            inValidA = 1'b1;
        end
        for (int w = 0; w < 40; w++) begin
            @(negedge clock);
            if ((useB ? inReadyB : inReadyA) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            waits++;
        end
        if (!ok) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL accept_timeout: in_ready never rose for data %0d", data);
        end
        @(posedge clock);
        #2;
        if (!keepValid) begin
            if (useB) inValidB = 1'b0;
            else      inValidA = 1'b0;
        end
    endtask

    // Monitor: pops the scoreboard on y_valid and checks per-phase control outputs of A.
    initial begin
        int phase;
        int accCyc;
        forever begin
            @(negedge clock);
            cyc++;
            if (reset) begin
                expQA.delete();
                expQB.delete();
                acceptQ.delete();
                busy       = 1'b0;
                haveAccept = 1'b0;
                validRun   = 1'b0;
            end else begin
                if (yValidA === 1'b1) begin
                    if (expQA.size() == 0 || acceptQ.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("[TB] FAIL unexpected_y_valid_A: got y_data %0d, expected no output", yDataA);
                    end else begin
                        accCyc = acceptQ.pop_front();
                        checkOutput("y_data_A", int'(yDataA), expQA.pop_front());
                        checkOutput("y_latency_A", cyc - accCyc, 11);
                    end
                end
                if (yValidB === 1'b1) begin
                    if (expQB.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("[TB] FAIL unexpected_y_valid_B: got y_data %0d, expected no output", yDataB);
                    end else begin
                        checkOutput("y_data_B", int'(yDataB), expQB.pop_front());
                    end
                end
                if (busy) begin
                    phase = cyc - lastAccept;
                    if (phase >= 1 && phase <= 10) begin
                        checkOutput($sformatf("ctrl_phase%0d", phase),
                                    int'({inReadyA, ramEnA, ramWeA, ramAddrA}),
                                    int'({1'b0, (phase <= 9) ? 1'b1 : 1'b0,
                                          (phase == 1) ? 1'b1 : 1'b0,
                                          (phase >= 2 && phase <= 9) ? 3'(phase - 2) : 3'd0}));
                    end
                    if (phase >= 11) busy = 1'b0;
                end
                if (inValidA !== 1'b1) validRun = 1'b0;
                if (inValidA === 1'b1 && inReadyA === 1'b1) begin
                    if (haveAccept && validRun) begin
                        checkOutput("accept_spacing", cyc - lastAccept, 11);
                    end
                    acceptQ.push_back(cyc);
                    lastAccept = cyc;
                    haveAccept = 1'b1;
                    busy       = 1'b1;
                    validRun   = 1'b1;
                end
            end
        end
    end

    initial begin
        int waits;
        int impulseIn [8]  = '{1, 0, 0, 0, 0, 0, 0, 0};
        int impulseExp [8] = '{1, 2, 3, 4, 4, 3, 2, 1};
        int stepExp [8]    = '{1, 3, 6, 10, 14, 17, 19, 20};
        int bpIn [4]       = '{2, 3, 4, 5};
        int bpExp [4]      = '{21, 24, 30, 40};

        $display("[TB] starting fir_mac_ctrl bench");
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("reset_y_valid", int'(yValidA), 0);
        checkOutput("reset_y_data", int'(yDataA), 0);
        checkOutput("reset_ram_en", int'(ramEnA), 0);
        checkOutput("reset_ram_we", int'(ramWeA), 0);
        checkOutput("reset_in_ready", int'(inReadyA), 1);
        checkOutput("reset_y_valid_B", int'(yValidB), 0);
        @(posedge clock);
        #2;
        reset = 1'b0;

        $display("[TB] impulse");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 8'(impulseIn[i]), impulseExp[i], 1'b0, waits);
            if (i == 0) checkOutput("first_accept_wait", waits, 0);
        end

        $display("[TB] step");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 8'd1, stepExp[i], 1'b0, waits);
        end

        $display("[TB] back-pressure");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 8'(bpIn[i]), bpExp[i], (i < 3), waits);
        end

        $display("[TB] reset mid-operation");
        applyStimulus(1'b0, 8'd7, 0, 1'b0, waits);
        repeat (5) @(posedge clock);
        #2;
        checkOutput("midop_ram_addr", int'(ramAddrA), 4);
        reset = 1'b1;
        @(posedge clock);
        #2;
        reset = 1'b0;
        repeat (15) @(posedge clock);
        #2;
        applyStimulus(1'b0, 8'd1, 1, 1'b0, waits);
        applyStimulus(1'b0, 8'd0, 2, 1'b0, waits);

        $display("[TB] extremes");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 8'h80, -16256 * (i + 1), 1'b0, waits);
        end

        for (int t = 0; t < 60; t++) begin
            @(negedge clock);
            if (expQA.size() == 0 && expQB.size() == 0) break;
        end
        if (expQA.size() != 0 || expQB.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain_timeout: %0d outputs outstanding, expected 0",
                     expQA.size() + expQB.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
